// File: rtl/match_sequencer.sv
// Match-level sequencer wrapped around a single-round reaction game FSM.
// It spaces rounds with a reset gap, judges false starts and grants, and tracks the score.
module match_sequencer #(
   parameter int ROUNDS_TO_WIN = 3,
   parameter int GAP_CYCLES    = 1000
) (
   input  logic       clk,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic       req1,
   input  logic       req2,
   input  logic       cd_active,
   input  logic       gnt1,
   input  logic       gnt2,
   input  logic       round_done,
   output logic       game_rst_n_out,
   output logic [2:0] score1_out,
   output logic [2:0] score2_out,
   output logic [1:0] match_winner_out,
   output logic [1:0] foul_out,
   output logic       busy_out
);

   localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [2:0]    WIN_CNT  = 3'(ROUNDS_TO_WIN);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, GAP, PLAY, SCORE, MATCH_END} state_t;

   state_t        state, next_state;
   logic [CW-1:0] gap_cnt;
   logic          res_vld;
   logic          res_p2;
   logic [1:0]    foul_reg;
   logic [2:0]    score1, score2;
   logic [1:0]    winner;

   logic       fs_single, fs_both, grant_now, p1_win, p2_win, gap_entry;
   logic [2:0] score1_inc, score2_inc;

   // A false start only counts while no grant has settled the round yet.
   assign fs_single  = (state == PLAY) && cd_active && !res_vld && (req1 ^ req2);
   assign fs_both    = (state == PLAY) && cd_active && !res_vld && req1 && req2;
   assign grant_now  = !res_vld && (gnt1 || gnt2);
   assign score1_inc = score1 + 3'd1;
   assign score2_inc = score2 + 3'd1;
   assign p1_win     = res_vld && !res_p2 && (score1_inc == WIN_CNT);
   assign p2_win     = res_vld &&  res_p2 && (score2_inc == WIN_CNT);
   assign gap_entry  = (next_state == GAP) && (state != GAP);

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (start_in) next_state = GAP;
         GAP:       if (gap_cnt == '0) next_state = PLAY;
         PLAY: begin
            if (fs_single)       next_state = SCORE;
            else if (fs_both)    next_state = GAP;
            else if (round_done) next_state = (res_vld || gnt1 || gnt2) ? SCORE : GAP;
         end
         SCORE:     next_state = (p1_win || p2_win) ? MATCH_END : GAP;
         MATCH_END: if (start_in) next_state = GAP;
         default:   next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         gap_cnt  <= '0;
         res_vld  <= 1'b0;
         res_p2   <= 1'b0;
         foul_reg <= 2'b00;
         score1   <= 3'd0;
         score2   <= 3'd0;
         winner   <= 2'b00;
      end else begin
         if (gap_entry) begin
            gap_cnt  <= GAP_LOAD;
            res_vld  <= 1'b0;
            res_p2   <= 1'b0;
            foul_reg <= 2'b00;
            if (state == IDLE || state == MATCH_END) begin
               score1 <= 3'd0;
               score2 <= 3'd0;
               winner <= 2'b00;
            end
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end

         if (state == PLAY) begin
            if (fs_single) begin
               res_vld  <= 1'b1;
               res_p2   <= req1;
               foul_reg <= req1 ? 2'b01 : 2'b10;
            end else if (!fs_both && grant_now) begin
               res_vld <= 1'b1;
               res_p2  <= gnt2;
            end
         end

         // Capped increments keep the score from ever passing the win count.
         if (state == SCORE && res_vld) begin
            if (!res_p2 && score1 < WIN_CNT) score1 <= score1_inc;
            if ( res_p2 && score2 < WIN_CNT) score2 <= score2_inc;
            if (p1_win)      winner <= 2'b01;
            else if (p2_win) winner <= 2'b10;
         end
      end
   end

   assign game_rst_n_out   = (state == PLAY);
   assign busy_out         = (state == GAP) || (state == PLAY) || (state == SCORE);
   assign foul_out         = (state == SCORE) ? foul_reg : 2'b00;
   assign score1_out       = score1;
   assign score2_out       = score2;
   assign match_winner_out = winner;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with ROUNDS_TO_WIN=2, GAP_CYCLES=4.
module tb_match_sequencer;

   logic       clk = 1'b0;
   logic       rst_in, start_in, req1, req2, cd_active, gnt1, gnt2, round_done;
   logic       game_rst_n_out, busy_out;
   logic [2:0] score1_out, score2_out;
   logic [1:0] match_winner_out, foul_out;

   int checks = 0;
   int errors = 0;

   match_sequencer #(.ROUNDS_TO_WIN(2), .GAP_CYCLES(4)) dut (
      .clk(clk), .rst_in(rst_in), .start_in(start_in), .req1(req1), .req2(req2),
      .cd_active(cd_active), .gnt1(gnt1), .gnt2(gnt2), .round_done(round_done),
      .game_rst_n_out(game_rst_n_out), .score1_out(score1_out), .score2_out(score2_out),
      .match_winner_out(match_winner_out), .foul_out(foul_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [1:0] win, input logic [1:0] foul,
                           input logic rn, input logic busy);
      chk({tag, ".score1"}, 8'(score1_out), 8'(s1));
      chk({tag, ".score2"}, 8'(score2_out), 8'(s2));
      chk({tag, ".winner"}, 8'(match_winner_out), 8'(win));
      chk({tag, ".foul"}, 8'(foul_out), 8'(foul));
      chk({tag, ".game_rst_n"}, 8'(game_rst_n_out), 8'(rn));
      chk({tag, ".busy"}, 8'(busy_out), 8'(busy));
   endtask

   // Called on the first GAP cycle; game reset must stay low four cycles, then rise.
   task automatic wait_gap(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, ".gap_low"}, 8'(game_rst_n_out), 8'd0);
         chk({tag, ".gap_busy"}, 8'(busy_out), 8'd1);
         tick();
      end
      chk({tag, ".play_high"}, 8'(game_rst_n_out), 8'd1);
   endtask

   initial begin
      rst_in = 1'b1; start_in = 1'b0; req1 = 1'b0; req2 = 1'b0;
      cd_active = 1'b0; gnt1 = 1'b0; gnt2 = 1'b0; round_done = 1'b0;
      #1;
      chk_outs("reset", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(); tick();
      rst_in = 1'b0;
      tick();
      chk_outs("idle", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);

      // Start; buttons pressed during the gap must not matter
      start_in = 1'b1; tick(); start_in = 1'b0;
      chk_outs("start", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1);
      req1 = 1'b1; cd_active = 1'b1;
      wait_gap("gap0");
      req1 = 1'b0; cd_active = 1'b0;
      chk_outs("play0", 3'd0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b1);

      // R1: P1 false start -> point to P2
      cd_active = 1'b1; req1 = 1'b1; tick();
      cd_active = 1'b0; req1 = 1'b0;
      chk_outs("fs1_score", 3'd0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b1);
      tick();
      chk_outs("fs1_after", 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap1");

      // Both false start -> replay
      cd_active = 1'b1; req1 = 1'b1; req2 = 1'b1; tick();
      cd_active = 1'b0; req1 = 1'b0; req2 = 1'b0;
      chk_outs("fs_both", 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap2");

      // round_done with no result -> replay
      round_done = 1'b1; tick(); round_done = 1'b0;
      chk_outs("nores", 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap3");

      // R3: gnt1 latched, later gnt2 ignored
      gnt1 = 1'b1; tick();
      gnt1 = 1'b0; gnt2 = 1'b1; round_done = 1'b1; tick();
      gnt2 = 1'b0; round_done = 1'b0;
      chk_outs("gnt1_score", 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      chk_outs("gnt1_after", 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap4");

      // R4: P2 false start -> P1 reaches 2, match over
      cd_active = 1'b1; req2 = 1'b1; tick();
      cd_active = 1'b0; req2 = 1'b0;
      chk_outs("fs2_score", 3'd1, 3'd1, 2'b00, 2'b10, 1'b0, 1'b1);
      tick();
      chk_outs("match_end", 3'd2, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0);
      gnt2 = 1'b1; round_done = 1'b1; req1 = 1'b1; cd_active = 1'b1;
      tick(); tick();
      gnt2 = 1'b0; round_done = 1'b0; req1 = 1'b0; cd_active = 1'b0;
      tick();
      chk_outs("end_hold", 3'd2, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0);

      // Restart from MATCH_END
      start_in = 1'b1; tick(); start_in = 1'b0;
      chk_outs("restart", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap5");

      // Grant and round_done in the same cycle
      gnt1 = 1'b1; round_done = 1'b1; tick();
      gnt1 = 1'b0; round_done = 1'b0;
      chk_outs("same_cyc", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      chk_outs("same_after", 3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap6");

      // Async reset mid-PLAY
      #2 rst_in = 1'b1;
      #1;
      chk_outs("async_rst", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      start_in = 1'b1; tick(); tick();
      chk_outs("rst_start", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      start_in = 1'b0; rst_in = 1'b0; tick(); tick();
      chk_outs("post_rst", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      start_in = 1'b1; tick(); start_in = 1'b0;
      chk_outs("fresh", 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1);
      wait_gap("gap7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS_TO_WIN, default 3: round wins needed to take the match (legal range 1..7).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000: cycles the game FSM is held in reset before each round (legal range ≥1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_in  input  1  synchronous request to start a new match.
REQ-006 SHALL have ports req1, req2  input  1 each  player buttons, already synchronized to clk.
REQ-007 SHALL have port cd_active  input  1  game FSM is in its countdown phase.
REQ-008 SHALL have ports gnt1, gnt2  input  1 each  grants from the game FSM, mutually exclusive.
REQ-009 SHALL have port round_done  input  1  level; game FSM has reached its end state.
REQ-010 SHALL have port game_rst_n_out  output  1  active-low reset to the game FSM.
REQ-011 SHALL have ports score1_out, score2_out  output  3 each  round-win counts.
REQ-012 SHALL have port match_winner_out  output  2  00 = none, 01 = player 1, 10 = player 2.
REQ-013 SHALL have port foul_out  output  2  one-cycle pulse naming the false-starting player (01 or 10).
REQ-014 SHALL have port busy_out  output  1  high while a match is in progress.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, GAP, PLAY, SCORE and MATCH_END; all outputs SHALL be registered or decoded from the state only.
REQ-016 IDLE: game_rst_n_out=0 and busy_out=0; start_in=1 SHALL clear both scores and match_winner_out and move to GAP.
REQ-017 GAP: game_rst_n_out=0 and busy_out=1; a down-counter SHALL be loaded with GAP_CYCLES-1 on entry; the FSM SHALL move to PLAY on the edge where the counter equals 0, so GAP lasts exactly GAP_CYCLES cycles.
REQ-018 PLAY: game_rst_n_out=1 and busy_out=1; the round result SHALL be latched on the first cycle in which gnt1 or gnt2 is 1 (gnt1 gives point to P1, gnt2 gives point to P2); later grant changes SHALL be ignored.
REQ-019 False start in PLAY, evaluated while cd_active=1:
- req1=1, req2=0: point to P2, foul=01, go to SCORE next cycle.
- req2=1, req1=0: point to P1, foul=10, go to SCORE next cycle.
- both=1: no point; go to GAP (replay).
REQ-020 PLAY with round_done=1 and a latched result SHALL go to SCORE; round_done=1 with no result SHALL go to GAP (replay, no score change).
REQ-021 SCORE SHALL last exactly 1 cycle:
- foul_out SHALL carry the registered foul code only during this cycle; otherwise it is 00.
- The point-holder's score SHALL increment on the edge leaving SCORE.
- If the new score equals ROUNDS_TO_WIN, go to MATCH_END and set match_winner_out; otherwise go to GAP.
REQ-022 Scores SHALL never exceed ROUNDS_TO_WIN.
REQ-023 The round-result latch SHALL clear on every entry to GAP.
REQ-024 MATCH_END: game_rst_n_out=0, busy_out=0, scores and match_winner_out held; start_in=1 SHALL clear scores and winner and go to GAP.
REQ-025 start_in SHALL be ignored in GAP, PLAY and SCORE.
REQ-026 req1 and req2 SHALL be ignored outside PLAY.

Reset
REQ-027 While rst_in=1, the block SHALL be in state IDLE with: score1_out=0, score2_out=0, match_winner_out=00, foul_out=00, game_rst_n_out=0, busy_out=0, GAP counter=0, round-result latch clear; this applies immediately, irrespective of clk.
REQ-028 Reset asserted mid-match (any state) SHALL abandon the match with no score update; after rst_in falls, the block SHALL wait in IDLE for start_in.

Verification (ROUNDS_TO_WIN=2, GAP_CYCLES=4)
REQ-029 Reset, then start_in pulse -> game_rst_n_out low for exactly 4 cycles then high, busy_out=1, scores 0/0.
REQ-030 In PLAY, gnt1=1 then round_done=1 -> one SCORE cycle, score1_out=1, foul_out=00, then GAP lasting 4 cycles.
REQ-031 cd_active=1 with req2=1, req1=0 -> foul_out=10 for 1 cycle, score1_out increments; cd_active=1 with req1=req2=1 -> scores unchanged, FSM goes to GAP.
REQ-032 P1 reaches 2 wins -> match_winner_out=01, busy_out=0, game_rst_n_out=0; gnt2 pulses afterwards change nothing; start_in -> scores 0/0, winner 00, GAP entered.
REQ-033 rst_in=1 during PLAY with score1_out=1 -> all outputs at their reset values asynchronously; start_in ignored while rst_in=1; after release, start_in begins a fresh match at 0/0.
